// File: rtl/kd_root_ctrl.sv
// kd_root_ctrl: top-of-tree controller for the k-means kd-tree.
// It configures the tree, runs N sort passes, then streams points one at a
// time into the root node and returns each point's cluster id.
// Optional feature macro: ROOT_TIMEOUT_EN. When it is defined, a bounded ack
// wait applies; on expiry the controller raises a sticky error, sends a single
// ABORT command and returns to IDLE.
module kd_root_ctrl #(
    parameter int COORD_W = 8,
    parameter int DIM     = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    localparam int DATA_W = COORD_W * DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_points,
    input  logic [3:0]        sort_passes,
    input  logic              point_valid,
    input  logic [DATA_W-1:0] point_in,
    output logic              point_ready,
    output logic              alert_to_root,
    output logic [2:0]        command_to_root,
    output logic [DATA_W-1:0] data_to_root,
    input  logic              alert_from_root,
    input  logic [2:0]        command_from_root,
    input  logic [DATA_W-1:0] data_from_root,
    output logic              result_valid,
    output logic [7:0]        result_id,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] CMD_CONFIGURE_SORT = 3'd1;
    localparam logic [2:0] CMD_START_SORT     = 3'd2;
    localparam logic [2:0] CMD_SORT_ACK       = 3'd3;
    localparam logic [2:0] CMD_CONFIG_ACK     = 3'd4;
    localparam logic [2:0] CMD_POINT          = 3'd5;
    localparam logic [2:0] CMD_POINT_ACK      = 3'd6;
    localparam logic [2:0] CMD_ABORT          = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_WCFG, S_SORT, S_WSORT,
        S_STREAM, S_SEND, S_WPT, S_DONE, S_ABORT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   np_r;
    logic [CNT_W-1:0]   pt_cnt;
    logic [3:0]         passes_r;
    logic [3:0]         pass_cnt;
    logic [DATA_W-1:0]  point_r;

    logic               waiting;
    logic [2:0]         exp_code;
    logic               ack_hit;
    logic               timeout_hit;
    logic [3:0]         pass_nxt;
    logic [CNT_W-1:0]   pt_nxt;

    // Only the low byte of the root payload carries the cluster id.
    logic unused_data_bits;
    assign unused_data_bits = ^data_from_root[DATA_W-1:8];

    assign pass_nxt = pass_cnt + 4'd1;
    assign pt_nxt   = pt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Which response (if any) the current state is waiting for; anything else is dropped.
    always_comb begin
        waiting  = 1'b1;
        exp_code = 3'd0;
        case (state)
            S_WCFG:  exp_code = CMD_CONFIG_ACK;
            S_WSORT: exp_code = CMD_SORT_ACK;
            S_WPT:   exp_code = CMD_POINT_ACK;
            default: waiting = 1'b0;
        endcase
    end

    assign ack_hit = waiting && alert_from_root && (command_from_root == exp_code);

`ifdef ROOT_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Wait counter restarts on every entry into a wait state.
    always_ff @(posedge clk) begin
        if (rst || !waiting) wait_cnt <= '0;
        else                 wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = waiting && !ack_hit && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Main control FSM; all outputs are registered, strobes default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            np_r            <= '0;
            pt_cnt          <= '0;
            passes_r        <= '0;
            pass_cnt        <= '0;
            point_r         <= '0;
            point_ready     <= 1'b0;
            alert_to_root   <= 1'b0;
            command_to_root <= '0;
            data_to_root    <= '0;
            result_valid    <= 1'b0;
            result_id       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            alert_to_root   <= 1'b0;
            command_to_root <= '0;
            data_to_root    <= '0;
            result_valid    <= 1'b0;
            done            <= 1'b0;

            if (timeout_hit) begin
                error           <= 1'b1;
                point_ready     <= 1'b0;
                alert_to_root   <= 1'b1;
                command_to_root <= CMD_ABORT;
                state           <= S_ABORT;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        np_r            <= num_points;
                        passes_r        <= (sort_passes == 4'd0) ? 4'd1 : sort_passes;
                        pass_cnt        <= '0;
                        pt_cnt          <= '0;
                        error           <= 1'b0;
                        busy            <= 1'b1;
                        alert_to_root   <= 1'b1;
                        command_to_root <= CMD_CONFIGURE_SORT;
                        state           <= S_CFG;
                    end
                    S_CFG:  state <= S_WCFG;
                    S_WCFG: if (ack_hit) begin
                        alert_to_root   <= 1'b1;
                        command_to_root <= CMD_START_SORT;
                        state           <= S_SORT;
                    end
                    S_SORT: state <= S_WSORT;
                    S_WSORT: if (ack_hit) begin
                        pass_cnt <= pass_nxt;
                        if (pass_nxt != passes_r) begin
                            alert_to_root   <= 1'b1;
                            command_to_root <= CMD_START_SORT;
                            state           <= S_SORT;
                        end else if (np_r == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            point_ready <= 1'b1;
                            state       <= S_STREAM;
                        end
                    end
                    S_STREAM: if (point_valid && point_ready) begin
                        point_r         <= point_in;
                        point_ready     <= 1'b0;
                        alert_to_root   <= 1'b1;
                        command_to_root <= CMD_POINT;
                        data_to_root    <= point_in;
                        state           <= S_SEND;
                    end
                    S_SEND: state <= S_WPT;
                    S_WPT: if (ack_hit) begin
                        result_valid <= 1'b1;
                        result_id    <= data_from_root[7:0];
                        pt_cnt       <= pt_nxt;
                        if (pt_nxt == np_r) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            point_ready <= 1'b1;
                            state       <= S_STREAM;
                        end
                    end
                    S_DONE, S_ABORT: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kd_root_ctrl.sv
// tb_kd_root_ctrl: scoreboard bench for kd_root_ctrl with a small root
// responder model that acks each command a few cycles after it is issued.
module tb_kd_root_ctrl;
    localparam int COORD_W = 8;
    localparam int DIM     = 3;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;
    localparam int DATA_W  = COORD_W * DIM;

    localparam logic [1:0] EV_CMD = 2'd1, EV_RES = 2'd2, EV_DONE = 2'd3;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_points;
    logic [3:0]        sort_passes;
    logic              point_valid;
    logic [DATA_W-1:0] point_in;
    logic              point_ready;
    logic              alert_to_root;
    logic [2:0]        command_to_root;
    logic [DATA_W-1:0] data_to_root;
    logic              alert_from_root = 1'b0;
    logic [2:0]        command_from_root = 3'd0;
    logic [DATA_W-1:0] data_from_root = '0;
    logic              result_valid;
    logic [7:0]        result_id;
    logic              busy;
    logic              done;
    logic              error;

    kd_root_ctrl #(.COORD_W(COORD_W), .DIM(DIM), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .sort_passes(sort_passes), .point_valid(point_valid), .point_in(point_in),
        .point_ready(point_ready), .alert_to_root(alert_to_root),
        .command_to_root(command_to_root), .data_to_root(data_to_root),
        .alert_from_root(alert_from_root), .command_from_root(command_from_root),
        .data_from_root(data_from_root), .result_valid(result_valid),
        .result_id(result_id), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  id_q[$];
    bit          auto_ack = 1'b0;
    int          inj_cnt = 0;
    int          inj_seen = 0;
    logic [2:0]  inj_cmd = 3'd0;
    bit          pr_seen = 1'b0;

    function automatic logic [31:0] ev(input logic [1:0] k, input logic [2:0] c,
                                       input logic [23:0] d);
        return {3'b0, k, c, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected event %h, nothing expected", name, act);
        end else begin
            check(name, {32'b0, act}, {32'b0, exp_q.pop_front()});
        end
    endtask

    // Monitor: every DUT strobe must match the next expected event.
    always @(negedge clk) begin
        if (point_ready) pr_seen = 1'b1;
        if (alert_to_root) pop_check("cmd", ev(EV_CMD, command_to_root, data_to_root));
        if (result_valid)  pop_check("result", ev(EV_RES, 3'd0, {16'b0, result_id}));
        if (done)          pop_check("done", ev(EV_DONE, 3'd0, 24'd0));
    end

    // Root model: acks each command 3 cycles later; also injects manual responses.
    int          cd = -1;
    logic [2:0]  pc = 3'd0;
    logic [23:0] pd = '0;
    always @(negedge clk) begin
        alert_from_root   = 1'b0;
        command_from_root = 3'd0;
        data_from_root    = '0;
        if (rst) begin
            cd = -1;
        end else begin
            if (cd == 0) begin
                alert_from_root   = 1'b1;
                command_from_root = pc;
                data_from_root    = pd;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (inj_cnt != inj_seen) begin
                inj_seen          = inj_cnt;
                alert_from_root   = 1'b1;
                command_from_root = inj_cmd;
                data_from_root    = '0;
            end
            if (alert_to_root && auto_ack) begin
                case (command_to_root)
                    3'd1: begin pc = 3'd4; pd = '0; cd = 2; end
                    3'd2: begin pc = 3'd3; pd = '0; cd = 2; end
                    3'd5: begin
                        pc = 3'd6;
                        pd = (id_q.size() != 0) ? {16'b0, id_q.pop_front()} : 24'hFFFFFF;
                        cd = 2;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [CNT_W-1:0] np, input logic [3:0] sp);
        @(negedge clk);
        num_points  = np;
        sort_passes = sp;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: busy still high after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_q_empty(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (point_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: point_ready never rose", name);
        end
    endtask

    task automatic feed(input logic [DATA_W-1:0] pt);
        point_in    = pt;
        point_valid = 1'b1;
        if (!point_ready) wait_ready("feed", 50);
        @(negedge clk);
        point_valid = 1'b0;
        point_in    = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return {23'b0, point_ready, alert_to_root, command_to_root, data_to_root,
                result_valid, result_id, busy, done, error};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; num_points = '0; sort_passes = '0;
        point_valid = 1'b0; point_in = '0;
        tick(3);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        // 1: zero points, one pass
        auto_ack = 1'b1;
        pr_seen  = 1'b0;
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_DONE, 3'd0, 24'd0));
        do_start(16'd0, 4'd1);
        check("busy_after_start", {63'b0, busy}, 64'd1);
        wait_idle("t1_idle", 100);
        check("t1_events_left", exp_q.size(), 64'd0);
        check("t1_no_point_ready", {63'b0, pr_seen}, 64'd0);
        check("t1_error", {63'b0, error}, 64'd0);

        // 2: three passes, two points
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        repeat (3) exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd5, 24'h0A0B0C));
        exp_q.push_back(ev(EV_RES, 3'd0, 24'd5));
        exp_q.push_back(ev(EV_CMD, 3'd5, 24'h010203));
        exp_q.push_back(ev(EV_RES, 3'd0, 24'd2));
        exp_q.push_back(ev(EV_DONE, 3'd0, 24'd0));
        id_q.push_back(8'd5);
        id_q.push_back(8'd2);
        do_start(16'd2, 4'd3);
        feed(24'h0A0B0C);
        feed(24'h010203);
        wait_idle("t2_idle", 200);
        check("t2_events_left", exp_q.size(), 64'd0);

        // 3: wrong-code response and mid-run start are both ignored
        auto_ack = 1'b0;
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        do_start(16'd0, 4'd1);
        tick(2);
        inj_cmd = 3'd3; inj_cnt++;
        do_start(16'd5, 4'd3);
        tick(6);
        check("t3_still_busy", {63'b0, busy}, 64'd1);
        check("t3_no_extra_cmd", exp_q.size(), 64'd0);
        exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_DONE, 3'd0, 24'd0));
        auto_ack = 1'b1;
        inj_cmd = 3'd4; inj_cnt++;
        wait_idle("t3_idle", 100);
        check("t3_events_left", exp_q.size(), 64'd0);

        // 4: point_valid held low while streaming
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd5, 24'hC0FFEE));
        exp_q.push_back(ev(EV_RES, 3'd0, 24'd9));
        exp_q.push_back(ev(EV_DONE, 3'd0, 24'd0));
        id_q.push_back(8'd9);
        do_start(16'd1, 4'd0);
        wait_ready("t4_ready", 100);
        for (int i = 0; i < 10; i++) begin
            check("t4_ready_held", {63'b0, point_ready}, 64'd1);
            @(negedge clk);
        end
        check("t4_no_point_yet", exp_q.size(), 64'd3);
        feed(24'hC0FFEE);
        wait_idle("t4_idle", 100);
        check("t4_events_left", exp_q.size(), 64'd0);

        // 5: reset while waiting for a point ack
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd5, 24'h123456));
        id_q.push_back(8'd77);
        do_start(16'd1, 4'd1);
        point_in = 24'h123456; point_valid = 1'b1;
        wait_q_empty("t5_point_sent", 100);
        point_valid = 1'b0; point_in = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        id_q.delete();
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
        repeat (2) exp_q.push_back(ev(EV_CMD, 3'd2, 24'd0));
        exp_q.push_back(ev(EV_CMD, 3'd5, 24'hABCDEF));
        exp_q.push_back(ev(EV_RES, 3'd0, 24'd3));
        exp_q.push_back(ev(EV_DONE, 3'd0, 24'd0));
        id_q.push_back(8'd3);
        do_start(16'd1, 4'd2);
        feed(24'hABCDEF);
        wait_idle("t5_idle", 200);
        check("t5_events_left", exp_q.size(), 64'd0);

        // 6: no CONFIG_ACK ever arrives
        auto_ack = 1'b0;
        exp_q.push_back(ev(EV_CMD, 3'd1, 24'd0));
`ifdef ROOT_TIMEOUT_EN
        exp_q.push_back(ev(EV_CMD, 3'd7, 24'd0));
        do_start(16'd0, 4'd1);
        wait_q_empty("t6_abort", 60);
        tick(3);
        check("t6_error", {63'b0, error}, 64'd1);
        check("t6_idle", {63'b0, busy}, 64'd0);
`else
        do_start(16'd0, 4'd1);
        tick(40);
        check("t6_stuck_busy", {63'b0, busy}, 64'd1);
        check("t6_error", {63'b0, error}, 64'd0);
        check("t6_no_extra_cmd", exp_q.size(), 64'd0);
`endif
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("final_outputs", all_outs(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
